updi_tx_serializer: RTL and testbench

- Downstream consumer of the UPDI instruction byte FIFO.
- Pops bytes and serializes each onto the single-wire UPDI line as an asynchronous frame: 1 start, 8 data LSB-first, even parity, 2 stop bits.
- Drives a tri-state enable so the line is released between frames for half-duplex receive.
- Also generates the UPDI BREAK condition on request.

---
 rtl/updi_tx_serializer.sv | 179 +++++++++++++++++
 tb/tb_updi_tx_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/updi_tx_serializer.sv
// UPDI transmit serializer.
// Pops bytes from the instruction FIFO and sends each as an asynchronous
// frame (start, 8 data bits LSB-first, even parity, 2 stop bits) on the
// single-wire UPDI line. It also generates a BREAK (line held low for
// BREAK_BITS bit times) on request.
//
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   baud_div     - clocks per bit minus 1, sampled at frame/break start
//   send_break   - one-cycle BREAK request (latched until serviced)
//   fifo_data    - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty   - FIFO empty flag
//   fifo_rd_en   - one-cycle FIFO pop strobe
//   tx, tx_en    - line value and drive enable (0 = released)
//   busy         - state != IDLE or a break is pending
//   byte_done    - one-cycle pulse as a frame returns to IDLE
module updi_tx_serializer #(
  parameter int DIV_BITS   = 16,
  parameter int BREAK_BITS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIV_BITS-1:0] baud_div,
  input  logic                send_break,
  input  logic [7:0]          fifo_data,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic                tx,
  output logic                tx_en,
  output logic                busy,
  output logic                byte_done
);

  // Bit index must count data bits (0..7) as well as break bits (0..BREAK_BITS).
  localparam int IW = ($clog2(BREAK_BITS + 1) > 3) ? $clog2(BREAK_BITS + 1) : 3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LATCH, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic                pend_q, pend_d;
  logic                tx_q, tx_d;
  logic                en_q, en_d;
  logic                rd_q, rd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    pend_d  = pend_q | send_break;

    if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP, S_BREAK})
      cnt_d = bit_end ? div_q : cnt_q - DIV_BITS'(1);

    case (state_q)
      S_IDLE: begin
        // The raw request is honoured here too so a break arriving together
        // with FIFO data still wins.
        if (pend_q || send_break) begin
          state_d = S_BREAK;
          pend_d  = 1'b0;
          div_d   = baud_div;
          cnt_d   = baud_div;
          idx_d   = '0;
        end else if (!fifo_empty) begin
          state_d = S_LOAD;
          div_d   = baud_div;
        end
      end
      S_LOAD:  state_d = S_LATCH;
      S_LATCH: begin
        shift_d = fifo_data;
        par_d   = ^fifo_data;
        cnt_d   = div_q;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IW'(7)) state_d = S_PARITY;
          else                 idx_d   = idx_q + IW'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == IW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_BREAK: begin
        if (bit_end) begin
          if (idx_q == IW'(BREAK_BITS)) state_d = S_IDLE;
          else                          idx_d   = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up
    // with the state register.
    en_d   = (state_d != S_IDLE);
    rd_d   = (state_d == S_LOAD);
    busy_d = (state_d != S_IDLE) | pend_d;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[idx_d[2:0]];
      S_PARITY: tx_d = par_q;
      S_BREAK:  tx_d = (idx_d >= IW'(BREAK_BITS));
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pend_q  <= 1'b0;
      tx_q    <= 1'b1;
      en_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pend_q  <= pend_d;
      tx_q    <= tx_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign tx_en      = en_q;
  assign fifo_rd_en = rd_q;
  assign busy       = busy_q;
  assign byte_done  = done_q;

endmodule

// File: tb/tb_updi_tx_serializer.sv
// Bench for updi_tx_serializer: FIFO model, per-cycle line recorder and a
// frame-level reference trace built from the UPDI framing rules.
module tb_updi_tx_serializer;
  localparam int BRK = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        send_break;
  logic [7:0]  fifo_data;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en, tx, tx_en, busy, byte_done;

  updi_tx_serializer #(.DIV_BITS(16), .BREAK_BITS(BRK)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .send_break(send_break),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .tx(tx), .tx_en(tx_en), .busy(busy), .byte_done(byte_done)
  );

  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;
  int underflow = 0;
  logic [7:0] fifo_q[$];
  // sample = {tx_en, tx, fifo_rd_en, byte_done, busy}
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  logic       rec_on = 1'b0;

  // FIFO: pop on the strobe, data valid the following cycle.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty || fifo_q.size() == 0) underflow++;
      else fifo_data <= fifo_q.pop_front();
    end
  end
  always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);

  always @(negedge clk)
    if (rec_on) obs_q.push_back({tx_en, tx, fifo_rd_en, byte_done, busy});

  // ---------------- reference trace ----------------
  function automatic void m_idle(int n, logic b);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, b});
  endfunction

  function automatic void m_frame(logic [7:0] d, int div, logic pend_after);
    logic [11:0] bits;
    bits = {2'b11, ^d, d, 1'b0};
    exp_q.push_back(5'b11101);  // pop cycle
    exp_q.push_back(5'b11001);  // latch cycle
    for (int i = 0; i < 12; i++)
      for (int j = 0; j <= div; j++) exp_q.push_back({1'b1, bits[i], 3'b001});
    exp_q.push_back({4'b0101, pend_after});  // line released, byte_done
  endfunction

  function automatic void m_break(int div);
    for (int i = 0; i < BRK * (div + 1); i++) exp_q.push_back(5'b10001);
    for (int i = 0; i <= div; i++) exp_q.push_back(5'b11001);
    m_idle(1, 1'b0);
  endfunction

  task automatic begin_rec();
    @(posedge clk);
    #1;
    obs_q.delete();
    rec_on = 1'b1;
  endtask

  task automatic end_rec_check(input string name);
    int n;
    int guard;
    int first;
    n = exp_q.size();
    guard = 0;
    while (obs_q.size() < n && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    rec_on = 1'b0;
    first = -1;
    for (int i = 0; i < n; i++)
      if (first < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) first = i;
    if (obs_q.size() != n && first < 0) first = n;
    tot++;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s: cycle %0d got {en,tx,rd,done,busy}=%b want %b (len %0d/%0d)", name, first,
               (first < obs_q.size()) ? obs_q[first] : 5'bx, (first < n) ? exp_q[first] : 5'bx,
               obs_q.size(), n);
    end
  endtask

  function automatic int count_bit(int b);
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i][b] === 1'b1) c++;
    return c;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; send_break = 1'b0; baud_div = 16'd3; fifo_data = '0;
    #2;
    tot++; if (tx !== 1'b1)         begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    tot++; if (tx_en !== 1'b0)      begin bad++; $display("FAIL reset_en: got %b want 0", tx_en); end
    tot++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", fifo_rd_en); end
    tot++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    tot++; if (byte_done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", byte_done); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_byte();
    exp_q.delete();
    m_idle(1, 1'b0); m_frame(8'h55, 3, 1'b0); m_idle(3, 1'b0);
    baud_div = 16'd3;
    begin_rec();
    fifo_q.push_back(8'h55);
    repeat (6) @(posedge clk);
    #1 baud_div = 16'd7;  // must not affect the frame already started
    end_rec_check("single_0x55");
    baud_div = 16'd3;
    tot++; if (count_bit(4) != 50) begin bad++; $display("FAIL single_en_cycles: got %0d want 50", count_bit(4)); end
    tot++; if (count_bit(2) != 1)  begin bad++; $display("FAIL single_rd_pulses: got %0d want 1", count_bit(2)); end
    tot++; if (count_bit(1) != 1)  begin bad++; $display("FAIL single_done_pulses: got %0d want 1", count_bit(1)); end
  endtask

  task automatic test_parity();
    exp_q.delete();
    m_idle(1, 1'b0); m_frame(8'h00, 0, 1'b0); m_frame(8'h01, 0, 1'b0); m_idle(3, 1'b0);
    baud_div = 16'd0;
    begin_rec();
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h01);
    end_rec_check("parity_b2b");
    if (obs_q.size() > 27) begin
      tot++; if (obs_q[12][3] !== 1'b0) begin bad++; $display("FAIL parity_0x00: got %b want 0", obs_q[12][3]); end
      tot++; if (obs_q[27][3] !== 1'b1) begin bad++; $display("FAIL parity_0x01: got %b want 1", obs_q[27][3]); end
      tot++; if ({obs_q[14][4], obs_q[15][4], obs_q[16][4]} !== 3'b101) begin
        bad++; $display("FAIL gap_en: got %b want 101", {obs_q[14][4], obs_q[15][4], obs_q[16][4]});
      end
    end else begin
      tot++; bad++; $display("FAIL parity_trace_len: got %0d want >27", obs_q.size());
    end
  endtask

  task automatic test_break();
    exp_q.delete();
    m_idle(1, 1'b0); m_break(1); m_idle(3, 1'b0);
    baud_div = 16'd1;
    begin_rec();
    send_break = 1'b1;
    @(posedge clk);
    #1 send_break = 1'b0;
    end_rec_check("break_idle");
    tot++; if (count_bit(2) != 0) begin bad++; $display("FAIL break_rd: got %0d want 0", count_bit(2)); end
    tot++; if (count_bit(1) != 0) begin bad++; $display("FAIL break_done: got %0d want 0", count_bit(1)); end
  endtask

  task automatic test_break_during_frame();
    exp_q.delete();
    m_idle(1, 1'b0); m_frame(8'hA3, 2, 1'b1); m_break(2); m_frame(8'h3C, 2, 1'b0); m_idle(3, 1'b0);
    baud_div = 16'd2;
    begin_rec();
    fifo_q.push_back(8'hA3);
    fifo_q.push_back(8'h3C);
    repeat (18) @(posedge clk);  // inside data bit 4
    #1 send_break = 1'b1;
    @(posedge clk);
    #1 send_break = 1'b0;
    repeat (4) @(posedge clk);   // second request collapses into the first
    #1 send_break = 1'b1;
    @(posedge clk);
    #1 send_break = 1'b0;
    end_rec_check("break_mid_frame");
  endtask

  task automatic test_empty();
    int errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || tx_en !== 1'b0 || busy !== 1'b0) errs++;
    end
    tot++; if (errs != 0) begin bad++; $display("FAIL empty_idle: got %0d bad cycles want 0", errs); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    baud_div = 16'd3;
    @(posedge clk);
    #1 fifo_q.push_back(8'h2D);  // bit 4 is 0, so the reset is visible on tx
    repeat (24) @(posedge clk);
    #3;
    tot++; if ({tx_en, tx} !== 2'b10) begin bad++; $display("FAIL pre_reset_bit4: got %b want 10", {tx_en, tx}); end
    rst = 1'b1;
    #1;
    tot++; if ({tx_en, tx, busy} !== 3'b010) begin
      bad++; $display("FAIL reset_mid: got {en,tx,busy}=%b want 010", {tx_en, tx, busy});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    d = 8'($urandom);
    exp_q.delete();
    m_idle(1, 1'b0); m_frame(d, 3, 1'b0); m_idle(3, 1'b0);
    begin_rec();
    fifo_q.push_back(d);
    end_rec_check("after_reset_frame");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int div;
      int nb;
      logic brk;
      logic [7:0] bytes[3];
      div = int'($urandom_range(0, 3));
      nb  = int'($urandom_range(1, 3));
      brk = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) bytes[k] = 8'($urandom);
      exp_q.delete();
      m_idle(1, 1'b0);
      if (brk) m_break(div);
      for (int k = 0; k < nb; k++) m_frame(bytes[k], div, 1'b0);
      m_idle(3, 1'b0);
      baud_div = 16'(div);
      begin_rec();
      for (int k = 0; k < nb; k++) fifo_q.push_back(bytes[k]);
      if (brk) begin
        send_break = 1'b1;
        @(posedge clk);
        #1 send_break = 1'b0;
      end
      end_rec_check($sformatf("random_%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_break();
    test_break_during_frame();
    test_empty();
    test_reset_mid_frame();
    test_random();
    tot++; if (underflow != 0) begin bad++; $display("FAIL pop_while_empty: got %0d want 0", underflow); end
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
